// File: rtl/scoreboard_register_file_pkg.sv
// Shared register-file constants for decode, scoreboard and writeback.
// Provides default WIDTH/ADDR_BITS and the DEPTH derivation helper.
package regfile_pkg;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_ADDR_BITS = 5;
    localparam int DEF_DEPTH     = 2 ** DEF_ADDR_BITS;

    function automatic int depth_of(input int addr_bits);
        return 2 ** addr_bits;
    endfunction

endpackage

// File: rtl/scoreboard_register_file_if.sv
// Decode/writeback bundle for the scoreboarded register file.
// master: pipeline side (addresses, write, mark); slave: the register file.
interface scoreboard_register_file_if
    import regfile_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ADDR_BITS = DEF_ADDR_BITS
);

    logic [ADDR_BITS-1:0] A1;
    logic [ADDR_BITS-1:0] A2;
    logic [WIDTH-1:0]     RD1;
    logic [WIDTH-1:0]     RD2;
    logic                 BUSY1;
    logic                 BUSY2;
    logic [ADDR_BITS-1:0] A3;
    logic                 WE3;
    logic [WIDTH-1:0]     WD3;
    logic                 MARK;
    logic [ADDR_BITS-1:0] MA;
    logic                 STALL;
    logic [ADDR_BITS:0]   PEND_CNT;

    modport master (
        output A1, A2, A3, WE3, WD3, MARK, MA,
        input  RD1, RD2, BUSY1, BUSY2, STALL, PEND_CNT
    );

    modport slave (
        input  A1, A2, A3, WE3, WD3, MARK, MA,
        output RD1, RD2, BUSY1, BUSY2, STALL, PEND_CNT
    );

endinterface

// File: rtl/scoreboard_register_file_scoreboard.sv
// reg_scoreboard: per-entry pending bits, pending counter, set/clear priority.
// Ports: clk/rst_n, write (we/wa), mark (mark/ma), read addrs -> busy1/2, cnt.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter bit ZERO_REG  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] wa,
    input  logic                 mark,
    input  logic [ADDR_BITS-1:0] ma,
    input  logic [ADDR_BITS-1:0] ra1,
    input  logic [ADDR_BITS-1:0] ra2,
    output logic                 busy1,
    output logic                 busy2,
    output logic [ADDR_BITS:0]   cnt
);

    localparam int DEPTH = depth_of(ADDR_BITS);
    localparam int CW    = ADDR_BITS + 1;

    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pend_nxt;
    logic             set_v;
    logic             clr_v;
    logic             inc;
    logic             dec;

    assign set_v = mark && !(ZERO_REG && ma == '0);
    assign clr_v = we && !(ZERO_REG && wa == '0);

    // A mark is the newer producer, so it wins over a write to the same entry.
    always_comb begin
        pend_nxt = pend;
        if (clr_v) pend_nxt[wa] = 1'b0;
        if (set_v) pend_nxt[ma] = 1'b1;
    end

    assign inc = set_v && !pend[ma];
    assign dec = clr_v && pend[wa] && !(set_v && ma == wa);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            cnt  <= '0;
        end else begin
            pend <= pend_nxt;
            cnt  <= cnt + CW'(inc) - CW'(dec);
        end
    end

    // A same-cycle write bypasses its data, so the reader need not wait.
    always_comb begin
        busy1 = pend[ra1] && !(we && wa == ra1);
        busy2 = pend[ra2] && !(we && wa == ra2);
        if (ZERO_REG && ra1 == '0) busy1 = 1'b0;
        if (ZERO_REG && ra2 == '0) busy2 = 1'b0;
    end

endmodule

// File: rtl/scoreboard_register_file.sv
// Scoreboarded register file: 2 combinational reads with write bypass, 1 write.
// Ports: CLK, RESETn (async active-low), bus (slave side of the regfile bundle).
module scoreboard_register_file
    import regfile_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter bit ZERO_REG  = 1'b1
) (
    input  logic                       CLK,
    input  logic                       RESETn,
    scoreboard_register_file_if.slave  bus
);

    localparam int DEPTH = depth_of(ADDR_BITS);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;
    logic             byp_ok;

    assign wr_ok  = bus.WE3 && !(ZERO_REG && bus.A3 == '0);
    // Bypass is held off during reset so reads show the cleared array.
    assign byp_ok = wr_ok && RESETn;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[bus.A3] <= bus.WD3;
        end
    end

    always_comb begin
        bus.RD1 = mem[bus.A1];
        if (byp_ok && bus.A3 == bus.A1) bus.RD1 = bus.WD3;
        if (ZERO_REG && bus.A1 == '0) bus.RD1 = '0;
    end

    always_comb begin
        bus.RD2 = mem[bus.A2];
        if (byp_ok && bus.A3 == bus.A2) bus.RD2 = bus.WD3;
        if (ZERO_REG && bus.A2 == '0) bus.RD2 = '0;
    end

    reg_scoreboard #(
        .ADDR_BITS (ADDR_BITS),
        .ZERO_REG  (ZERO_REG)
    ) u_sb (
        .clk   (CLK),
        .rst_n (RESETn),
        .we    (bus.WE3),
        .wa    (bus.A3),
        .mark  (bus.MARK),
        .ma    (bus.MA),
        .ra1   (bus.A1),
        .ra2   (bus.A2),
        .busy1 (bus.BUSY1),
        .busy2 (bus.BUSY2),
        .cnt   (bus.PEND_CNT)
    );

    assign bus.STALL = bus.BUSY1 | bus.BUSY2;

endmodule

// File: tb/tb_scoreboard_register_file.sv
// Directed self-checking bench for scoreboard_register_file.
// Inputs change 1ns after CLK rise; outputs sampled mid-cycle.
module tb_scoreboard_register_file;

    logic CLK = 1'b0;
    logic RESETn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    scoreboard_register_file_if #(.WIDTH(32), .ADDR_BITS(5)) bus ();

    scoreboard_register_file #(
        .WIDTH     (32),
        .ADDR_BITS (5),
        .ZERO_REG  (1'b1)
    ) dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .bus    (bus)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.WE3  = 1'b0;
        bus.MARK = 1'b0;
        bus.A3   = '0;
        bus.MA   = '0;
        bus.WD3  = '0;
    endtask

    task automatic do_reset();
        idle();
        RESETn = 1'b0;
        #2;
        RESETn = 1'b1;
        step();
    endtask

    task automatic test_reset();
        bus.A1 = 5'd5;
        bus.A2 = 5'd2;
        idle();
        #1;
        checks++;
        if (bus.RD1 !== 32'h0 || bus.PEND_CNT !== 6'd0 || bus.STALL !== 1'b0) begin
            errors++;
            $display("FAIL reset_init: rd1=%h cnt=%0d stall=%b required 0/0/0",
                     bus.RD1, bus.PEND_CNT, bus.STALL);
        end
        RESETn = 1'b1;
        step();
        bus.WE3 = 1'b1; bus.A3 = 5'd5; bus.WD3 = 32'hDEADBEEF;
        bus.MARK = 1'b1; bus.MA = 5'd2;
        step();
        idle();
        #1;
        checks++;
        if (bus.RD1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL reset_prewrite: rd1=%h required deadbeef", bus.RD1);
        end
        checks++;
        if (bus.BUSY2 !== 1'b1 || bus.PEND_CNT !== 6'd1) begin
            errors++;
            $display("FAIL reset_premark: busy2=%b cnt=%0d required 1/1",
                     bus.BUSY2, bus.PEND_CNT);
        end
        #2;
        RESETn = 1'b0;
        #1;
        checks++;
        if (bus.RD1 !== 32'h0 || bus.PEND_CNT !== 6'd0 ||
            bus.BUSY2 !== 1'b0 || bus.STALL !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: rd1=%h cnt=%0d busy2=%b stall=%b required 0",
                     bus.RD1, bus.PEND_CNT, bus.BUSY2, bus.STALL);
        end
        bus.WE3 = 1'b1; bus.A3 = 5'd5; bus.WD3 = 32'h11111111;
        bus.MARK = 1'b1; bus.MA = 5'd5;
        step();
        idle();
        #1;
        checks++;
        if (bus.RD1 !== 32'h0 || bus.PEND_CNT !== 6'd0) begin
            errors++;
            $display("FAIL reset_ignore: rd1=%h cnt=%0d required 0/0",
                     bus.RD1, bus.PEND_CNT);
        end
        RESETn = 1'b1;
        step();
    endtask

    task automatic test_bypass();
        do_reset();
        bus.WE3 = 1'b1; bus.A3 = 5'd7; bus.WD3 = 32'h12345678;
        bus.A1 = 5'd7; bus.A2 = 5'd6;
        #1;
        checks++;
        if (bus.RD1 !== 32'h12345678 || bus.RD2 !== 32'h0) begin
            errors++;
            $display("FAIL bypass_same: rd1=%h rd2=%h required 12345678/0",
                     bus.RD1, bus.RD2);
        end
        step();
        idle();
        #1;
        checks++;
        if (bus.RD1 !== 32'h12345678) begin
            errors++;
            $display("FAIL bypass_after: rd1=%h required 12345678", bus.RD1);
        end
        bus.A2 = 5'd7;
        #1;
        checks++;
        if (bus.RD2 !== 32'h12345678) begin
            errors++;
            $display("FAIL bypass_rd2: rd2=%h required 12345678", bus.RD2);
        end
    endtask

    task automatic test_zero();
        do_reset();
        bus.WE3 = 1'b1; bus.A3 = 5'd0; bus.WD3 = 32'hFFFFFFFF;
        bus.MARK = 1'b1; bus.MA = 5'd0;
        bus.A1 = 5'd0; bus.A2 = 5'd0;
        #1;
        checks++;
        if (bus.RD1 !== 32'h0 || bus.RD2 !== 32'h0) begin
            errors++;
            $display("FAIL zero_same: rd1=%h rd2=%h required 0", bus.RD1, bus.RD2);
        end
        step();
        idle();
        #1;
        checks++;
        if (bus.RD1 !== 32'h0 || bus.BUSY1 !== 1'b0 || bus.PEND_CNT !== 6'd0) begin
            errors++;
            $display("FAIL zero_after: rd1=%h busy1=%b cnt=%0d required 0/0/0",
                     bus.RD1, bus.BUSY1, bus.PEND_CNT);
        end
    endtask

    task automatic test_scoreboard();
        do_reset();
        bus.MARK = 1'b1; bus.MA = 5'd3;
        step();
        bus.MA = 5'd9;
        step();
        idle();
        bus.A1 = 5'd3; bus.A2 = 5'd9;
        #1;
        checks++;
        if (bus.PEND_CNT !== 6'd2 || bus.BUSY1 !== 1'b1 ||
            bus.BUSY2 !== 1'b1 || bus.STALL !== 1'b1) begin
            errors++;
            $display("FAIL sb_marked: cnt=%0d b1=%b b2=%b stall=%b required 2/1/1/1",
                     bus.PEND_CNT, bus.BUSY1, bus.BUSY2, bus.STALL);
        end
        bus.WE3 = 1'b1; bus.A3 = 5'd3; bus.WD3 = 32'h00000033;
        #1;
        checks++;
        if (bus.BUSY1 !== 1'b0 || bus.STALL !== 1'b1) begin
            errors++;
            $display("FAIL sb_wr_cycle: busy1=%b stall=%b required 0/1",
                     bus.BUSY1, bus.STALL);
        end
        step();
        idle();
        bus.A2 = 5'd3;
        #1;
        checks++;
        if (bus.PEND_CNT !== 6'd1 || bus.BUSY1 !== 1'b0 || bus.RD1 !== 32'h33) begin
            errors++;
            $display("FAIL sb_after_wr: cnt=%0d busy1=%b rd1=%h required 1/0/33",
                     bus.PEND_CNT, bus.BUSY1, bus.RD1);
        end
        bus.MARK = 1'b1; bus.MA = 5'd10; bus.A1 = 5'd10;
        #1;
        checks++;
        if (bus.BUSY1 !== 1'b0 || bus.STALL !== 1'b0) begin
            errors++;
            $display("FAIL sb_mark_same_cycle: busy1=%b stall=%b required 0/0",
                     bus.BUSY1, bus.STALL);
        end
        step();
        idle();
        #1;
        checks++;
        if (bus.BUSY1 !== 1'b1 || bus.PEND_CNT !== 6'd2) begin
            errors++;
            $display("FAIL sb_mark_next: busy1=%b cnt=%0d required 1/2",
                     bus.BUSY1, bus.PEND_CNT);
        end
    endtask

    task automatic test_simul();
        do_reset();
        bus.MARK = 1'b1; bus.MA = 5'd4;
        bus.WE3 = 1'b1; bus.A3 = 5'd4; bus.WD3 = 32'h000000A5;
        step();
        idle();
        bus.A1 = 5'd4;
        #1;
        checks++;
        if (bus.RD1 !== 32'hA5 || bus.BUSY1 !== 1'b1 || bus.PEND_CNT !== 6'd1) begin
            errors++;
            $display("FAIL simul_same: rd1=%h busy1=%b cnt=%0d required a5/1/1",
                     bus.RD1, bus.BUSY1, bus.PEND_CNT);
        end
        bus.MARK = 1'b1; bus.MA = 5'd6;
        bus.WE3 = 1'b1; bus.A3 = 5'd4; bus.WD3 = 32'h000000A6;
        step();
        idle();
        bus.A2 = 5'd6;
        #1;
        checks++;
        if (bus.PEND_CNT !== 6'd1 || bus.BUSY1 !== 1'b0 ||
            bus.BUSY2 !== 1'b1 || bus.RD1 !== 32'hA6) begin
            errors++;
            $display("FAIL simul_diff: cnt=%0d b1=%b b2=%b rd1=%h required 1/0/1/a6",
                     bus.PEND_CNT, bus.BUSY1, bus.BUSY2, bus.RD1);
        end
        bus.WE3 = 1'b1; bus.A3 = 5'd12; bus.WD3 = 32'h0000000C;
        step();
        idle();
        #1;
        checks++;
        if (bus.PEND_CNT !== 6'd1) begin
            errors++;
            $display("FAIL simul_nonpend_wr: cnt=%0d required 1", bus.PEND_CNT);
        end
    endtask

    task automatic test_sweep();
        int busy_bad;
        do_reset();
        bus.MARK = 1'b1;
        for (int i = 1; i < 32; i++) begin
            bus.MA = 5'(i);
            step();
        end
        idle();
        #1;
        checks++;
        if (bus.PEND_CNT !== 6'd31) begin
            errors++;
            $display("FAIL sweep_full: cnt=%0d required 31", bus.PEND_CNT);
        end
        busy_bad = 0;
        for (int i = 0; i < 32; i++) begin
            bus.A1 = 5'(i);
            #1;
            if (bus.BUSY1 !== (i != 0)) busy_bad++;
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL sweep_busy: %0d entries wrong, required 0", busy_bad);
        end
        bus.MARK = 1'b1; bus.MA = 5'd1;
        step();
        bus.MA = 5'd0;
        step();
        idle();
        #1;
        checks++;
        if (bus.PEND_CNT !== 6'd31) begin
            errors++;
            $display("FAIL sweep_remark: cnt=%0d required 31", bus.PEND_CNT);
        end
        bus.WE3 = 1'b1;
        for (int i = 1; i < 32; i++) begin
            bus.A3 = 5'(i);
            bus.WD3 = 32'(i) * 32'h01010101;
            step();
        end
        idle();
        bus.A1 = 5'd17; bus.A2 = 5'd31;
        #1;
        checks++;
        if (bus.PEND_CNT !== 6'd0 || bus.STALL !== 1'b0) begin
            errors++;
            $display("FAIL sweep_clear: cnt=%0d stall=%b required 0/0",
                     bus.PEND_CNT, bus.STALL);
        end
        checks++;
        if (bus.RD1 !== 32'h11111111 || bus.RD2 !== 32'h1F1F1F1F) begin
            errors++;
            $display("FAIL sweep_data: rd1=%h rd2=%h required 11111111/1f1f1f1f",
                     bus.RD1, bus.RD2);
        end
    endtask

    initial begin
        bus.A1 = '0;
        bus.A2 = '0;
        idle();
        test_reset();
        test_bypass();
        test_zero();
        test_scoreboard();
        test_simul();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
